bus_controller: RTL
===================

BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, maximum ACCESS cycles before an error response.
REQ-002 SHALL have port: clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: m0_req in 1, m0_we in 1, m0_addr in 64, m0_wdata in 64; master 0 is the CPU.
REQ-005 SHALL have ports: m0_ack out 1, m0_rdata out 64, m0_err out 1; master 0 response.
REQ-006 SHALL have ports: m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err; master 1 is the keyboard writer, with the same widths as m0.
REQ-007 SHALL have ports: s_valid out 1, s_we out 1, s_addr out 64, s_wdata out 64; shared slave request.
REQ-008 SHALL have port: s_sel  out  3  one-hot target select: bit0 RAM, bit1 UART, bit2 KEY.
REQ-009 SHALL have ports: s_ready in 1, s_rdata in 64; these come from the selected slave, muxed externally.
REQ-010 SHALL have port: busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL decode the RAM window as 0x0000_0000_0000_1000..0x0000_0000_0000_2FFF inclusive.
REQ-012 SHALL decode the UART window as 0x0000_0000_8000_0000..0x0000_0000_8000_0007.
REQ-013 SHALL decode the KEY window as 0x0000_0000_8000_0010..0x0000_0000_8000_0017.
REQ-014 SHALL treat any other address as unmapped, including any nonzero bit in [63:32].
REQ-015 SHALL implement FSM states IDLE, ACCESS and RESP, and SHALL leave no other reachable states.
REQ-016 SHALL, in IDLE with at least one req high, grant one master using a round-robin pointer.
REQ-017 SHALL grant on the rr pointer as follows: rr=0 prefers m0 and rr=1 prefers m1; a lone requester always wins.
REQ-018 SHALL, on grant, latch the granted master's addr, we and wdata plus the grant ID, and clear the timeout counter.
REQ-019 SHALL move from IDLE to ACCESS on grant of a mapped address.
REQ-020 SHALL move from IDLE to RESP on grant of an unmapped address, with err=1 and rdata=0, and SHALL never assert s_valid for it.
REQ-021 SHALL, in ACCESS, drive s_valid=1, s_sel=decoded one-hot, and s_addr/s_we/s_wdata from the latched values.
REQ-022 SHALL hold the ACCESS outputs stable until exit from ACCESS.
REQ-023 SHALL, in ACCESS with s_ready=1, latch s_rdata (write: 0), set err=0 and go to RESP.
REQ-024 SHALL, in ACCESS with s_ready=0, increment the counter each cycle.
REQ-025 SHALL, when the counter reaches TIMEOUT-1 with s_ready still 0, go to RESP with err=1 and rdata=0.
REQ-026 SHALL give s_ready priority over timeout when both occur in the same cycle.
REQ-027 SHALL, in RESP, pulse the granted master's ack for exactly one cycle with registered rdata/err.
REQ-028 SHALL hold the non-granted master's ack/err at 0 and its rdata at 0.
REQ-029 SHALL, in RESP, set rr to the ID other than the granted one and return to IDLE.
REQ-030 SHALL start no new grant in the RESP cycle, so back-to-back transactions are separated by one IDLE cycle.
REQ-031 SHALL require masters to hold req and payload until ack.
REQ-032 SHALL still complete and ack a transaction whose req drops after grant.
REQ-033 SHALL leave req from the non-granted master pending, to be served in a later IDLE.
REQ-034 SHALL have a minimum mapped latency of 2 cycles: req sampled at edge N, ACCESS at N+1, ack at N+2 when s_ready=1 at N+1.
REQ-035 SHALL have an unmapped latency of 1 cycle: ack at N+1.
REQ-036 SHALL drive s_valid, s_sel, s_we, s_addr and s_wdata to 0 outside ACCESS.

Reset
REQ-037 SHALL, on reset assertion, immediately and asynchronously set FSM=IDLE, rr=0 and counter=0.
REQ-038 SHALL, on reset assertion, immediately and asynchronously clear all latched fields and drive every output to 0.
REQ-039 SHALL abort any in-flight transaction on reset without ack.
REQ-040 SHALL evaluate its first grant on the first rising clk edge after reset deasserts.

Verification
REQ-041 SHALL cover CPU read: m0 reads 0x1000 and s_ready rises 3 cycles into ACCESS, giving s_sel=001 and m0_ack with m0_rdata=s_rdata=0xDEAD_BEEF and err=0.
REQ-042 SHALL cover contention: m0 and m1 both hold req from reset, giving the grant order m0, m1, m0, m1, each ack one cycle wide with one IDLE gap between.
REQ-043 SHALL cover keyboard write: m1 writes 0x41 to 0x8000_0000, giving s_sel=010, s_we=1, s_wdata=0x41 and m1_ack with err=0.
REQ-044 SHALL cover unmapped access: m0 accesses 0x1_0000_1000, giving m0_ack one cycle after grant with err=1, rdata=0 and s_valid never high.
REQ-045 SHALL cover timeout: with TIMEOUT=16 and s_ready held 0, m0_ack comes with err=1 after exactly 16 ACCESS cycles; s_ready on cycle 16 instead gives err=0.
REQ-046 SHALL cover reset mid-transaction: reset pulsed during ACCESS drops s_valid asynchronously with no ack, then after release a pending m1 is granted first (rr=0, m0 idle).

Source files
------------

// File: rtl/bus_controller_if.sv
// Bus bundle between two masters (CPU, keyboard writer), the controller and the shared slave mux.
// The `slave` modport is the controller's view: it serves the masters' requests and drives the
// shared slave request. The `master` modport is the surrounding environment's view.
interface bus_controller_if;
    // Master 0 (CPU)
    logic        m0_req;
    logic        m0_we;
    logic [63:0] m0_addr;
    logic [63:0] m0_wdata;
    logic        m0_ack;
    logic [63:0] m0_rdata;
    logic        m0_err;

    // Master 1 (keyboard writer)
    logic        m1_req;
    logic        m1_we;
    logic [63:0] m1_addr;
    logic [63:0] m1_wdata;
    logic        m1_ack;
    logic [63:0] m1_rdata;
    logic        m1_err;

    // Shared slave side; s_ready/s_rdata come from the externally muxed selected slave
    logic        s_valid;
    logic        s_we;
    logic [63:0] s_addr;
    logic [63:0] s_wdata;
    logic [2:0]  s_sel;
    logic        s_ready;
    logic [63:0] s_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output s_valid, s_we, s_addr, s_wdata, s_sel,
        input  s_ready, s_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  s_valid, s_we, s_addr, s_wdata, s_sel,
        output s_ready, s_rdata
    );
endinterface

// File: rtl/bus_controller.sv
// Two-master round-robin bus controller with address decode to RAM / UART / KEY and a per-access
// timeout. One transaction at a time: IDLE (arbitrate) -> ACCESS (drive slave) -> RESP (ack).
module bus_controller #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    bus_controller_if.slave bus,
    output logic            busy
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    localparam logic [31:0] RamLo    = 32'h0000_1000;
    localparam logic [31:0] RamHi    = 32'h0000_2FFF;
    localparam logic [31:0] UartBase = 32'h8000_0000;
    localparam logic [31:0] KeyBase  = 32'h8000_0010;

    localparam logic [2:0] SelNone = 3'b000;
    localparam logic [2:0] SelRam  = 3'b001;
    localparam logic [2:0] SelUart = 3'b010;
    localparam logic [2:0] SelKey  = 3'b100;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            rr_q, rr_d;       // 0 prefers m0, 1 prefers m1
    logic            gnt_q, gnt_d;     // ID of the master owning the current transaction
    logic [63:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [2:0]      sel_q, sel_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            req_any;
    logic            gnt_id;
    logic            req_we;
    logic [63:0]     req_addr;
    logic [63:0]     req_wdata;
    logic [2:0]      req_sel;

    // One-hot target decode; SelNone means unmapped (any upper-word bit set is unmapped)
    function automatic logic [2:0] decode(input logic [63:0] addr);
        logic [2:0] sel;
        sel = SelNone;
        if (addr[63:32] == 32'h0) begin
            if (addr[31:0] >= RamLo && addr[31:0] <= RamHi) begin
                sel = SelRam;
            end else if (addr[31:3] == UartBase[31:3]) begin
                sel = SelUart;
            end else if (addr[31:3] == KeyBase[31:3]) begin
                sel = SelKey;
            end
        end
        return sel;
    endfunction

    // Round-robin arbitration and payload select for the IDLE grant
    always_comb begin
        req_any = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            gnt_id = rr_q;
        end else begin
            gnt_id = bus.m1_req;
        end
        req_we    = gnt_id ? bus.m1_we    : bus.m0_we;
        req_addr  = gnt_id ? bus.m1_addr  : bus.m0_addr;
        req_wdata = gnt_id ? bus.m1_wdata : bus.m0_wdata;
        req_sel   = decode(req_addr);
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and transaction-field update logic
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    gnt_d   = gnt_id;
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    sel_d   = req_sel;
                    cnt_d   = '0;
                    if (req_sel != SelNone) begin
                        state_d = StAccess;
                    end else begin
                        // Unmapped: answer directly without ever touching the slave
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StAccess: begin
                // s_ready wins over a timeout landing in the same cycle
                if (bus.s_ready) begin
                    rdata_d = we_q ? 64'h0 : bus.s_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntMax) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                rr_d    = ~gnt_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Latched transaction fields, round-robin pointer and timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state only, so reset zeroes them without waiting for a clock
    always_comb begin
        bus.s_valid  = 1'b0;
        bus.s_we     = 1'b0;
        bus.s_addr   = '0;
        bus.s_wdata  = '0;
        bus.s_sel    = '0;
        bus.m0_ack   = 1'b0;
        bus.m0_rdata = '0;
        bus.m0_err   = 1'b0;
        bus.m1_ack   = 1'b0;
        bus.m1_rdata = '0;
        bus.m1_err   = 1'b0;
        busy         = (state_q != StIdle);
        unique case (state_q)
            StAccess: begin
                bus.s_valid = 1'b1;
                bus.s_we    = we_q;
                bus.s_addr  = addr_q;
                bus.s_wdata = wdata_q;
                bus.s_sel   = sel_q;
            end
            StResp: begin
                if (gnt_q) begin
                    bus.m1_ack   = 1'b1;
                    bus.m1_rdata = rdata_q;
                    bus.m1_err   = err_q;
                end else begin
                    bus.m0_ack   = 1'b1;
                    bus.m0_rdata = rdata_q;
                    bus.m0_err   = err_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
